// File: rtl/serial_deser_pkg.sv
// Shared definitions for the serial deserializer.
//   state_t        : FSM state encoding (IDLE=0, SHIFT=1)
//   DEFAULT_WIDTH  : default word width used by serial_deser
package serial_deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deser_bitcnt.sv
// Bit counter for the deserializer.
// It has a synchronous clear and an enable.
// It raises a terminal flag while the count equals WIDTH-1.
//   clk    in  1  clock
//   rst_n  in  1  synchronous active-low reset
//   clr    in  1  clear count to 0 (has priority over en)
//   en     in  1  increment count
//   tc     out 1  count == WIDTH-1
module deser_bitcnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer.
// It collects WIDTH bits, MSB first, into one word.
// The word is presented on a valid/ready interface.
//   clk         in   1      clock
//   rst_n       in   1      synchronous active-low reset
//   sin         in   1      serial data bit
//   sin_en      in   1      sin is valid this cycle
//   start       in   1      frame-start pulse (also restarts a frame in progress)
//   dout        out  WIDTH  assembled word, MSB = first bit received
//   dout_valid  out  1      dout holds an unconsumed word
//   dout_ready  in   1      downstream accepts dout this cycle
//   busy        out  1      frame in progress
//   overrun     out  1      sticky: a completed word was dropped
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | no frame in progress, waiting for start
// SHIFT | collecting bits; leaves on the last bit unless start
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
);

    state_t           state;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] word;
    logic             shift_en;
    logic             last_bit;
    logic             tc;

    // Only WIDTH-1 bits are stored.
    // The final bit goes straight from sin into the completed word.
    assign word     = {sr, sin};
    assign shift_en = (state == SHIFT) && sin_en;
    assign last_bit = shift_en && tc;

    // The counter also clears on the last bit.
    // That keeps it in range for widths that are not a power of two.
    deser_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start || last_bit),
        .en    (shift_en),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // start wins over the return to IDLE on the last bit
            if (start) begin
                state <= SHIFT;
            end else if (last_bit) begin
                state <= IDLE;
            end

            if (start) begin
                sr <= '0;
            end else if (shift_en) begin
                sr <= word[WIDTH-2:0];
            end

            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            // A completed word needs a free slot. The slot is free if it is
            // empty, or if it is being consumed in this same cycle.
            if (last_bit) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= word;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_deser.sv
module tb_serial_deser;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         sin;
    logic         sin_en;
    logic         start;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;

    int n_total;
    int n_pass;

    // Reference model state.
    // The frame is kept as a queue of received bits.
    bit           m_active;
    bit           m_bits[$];
    logic [W-1:0] m_dout;
    bit           m_valid;
    bit           m_ovr;

    serial_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_en     (sin_en),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit en, input bit st, input bit rdy);
        bit           complete;
        bit           can_load;
        logic [W-1:0] w;
        if (!r) begin
            m_active = 0;
            m_bits.delete();
            m_dout   = '0;
            m_valid  = 0;
            m_ovr    = 0;
            return;
        end
        complete = m_active && en && (m_bits.size() == W - 1);
        w = '0;
        if (complete) begin
            foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
            w = (w << 1) | W'(s);
        end
        can_load = !m_valid || rdy;
        if (m_valid && rdy) m_valid = 0;
        if (complete) begin
            if (can_load) begin
                m_dout  = w;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end
        if (st) begin
            m_active = 1;
            m_bits.delete();
        end else if (complete) begin
            m_active = 0;
            m_bits.delete();
        end else if (m_active && en) begin
            m_bits.push_back(s);
        end
    endtask

    // One clock: drive inputs, clock edge, advance model, compare outputs.
    task automatic cyc(input bit r, input bit s, input bit en, input bit st, input bit rdy);
        rst_n      = r;
        sin        = s;
        sin_en     = en;
        start      = st;
        dout_ready = rdy;
        @(posedge clk);
        model_step(r, s, en, st, rdy);
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_active));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit rdy, input bit gaps);
        logic [W-1:0] v;
        v = w;
        cyc(1, 1'($urandom), 1'($urandom), 1, rdy);
        for (int i = W - 1; i >= 0; i--) begin
            if (gaps) cyc(1, 1'($urandom), 0, 0, rdy);
            cyc(1, v[i], 1, 0, rdy);
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        sin        = 1'b0;
        sin_en     = 1'b0;
        start      = 1'b0;
        dout_ready = 1'b0;

        // 1: reset with random other inputs
        for (int i = 0; i < 3; i++)
            cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("t1_dout", 32'(dout), 32'h00);
        chk("t1_valid", 32'(dout_valid), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_ovr", 32'(overrun), 0);

        // 2: contiguous frame A5
        send_frame(8'hA5, 1, 0);
        chk("t2_dout", 32'(dout), 32'hA5);
        chk("t2_valid", 32'(dout_valid), 1);
        chk("t2_busy", 32'(busy), 0);

        // 3: same frame with gaps and junk while sin_en=0
        send_frame(8'hA5, 1, 1);
        chk("t3_dout", 32'(dout), 32'hA5);
        chk("t3_valid", 32'(dout_valid), 1);

        // 4: hold A5 under backpressure, then 3C is dropped
        cyc(1, 0, 0, 0, 1);
        chk("t4_drain", 32'(dout_valid), 0);
        send_frame(8'hA5, 0, 0);
        send_frame(8'h3C, 0, 0);
        chk("t4_dout", 32'(dout), 32'hA5);
        chk("t4_ovr", 32'(overrun), 1);
        cyc(1, 0, 0, 0, 1);
        chk("t4_valid", 32'(dout_valid), 0);
        chk("t4_dout_hold", 32'(dout), 32'hA5);
        for (int i = 0; i < 4; i++) cyc(1, 1'($urandom), 1'($urandom), 0, 1'($urandom));
        chk("t4_ovr_sticky", 32'(overrun), 1);

        // 5: restart mid-frame
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 1);
        send_frame(8'hFF, 1, 0);
        chk("t5_dout", 32'(dout), 32'hFF);
        chk("t5_valid", 32'(dout_valid), 1);
        chk("t5_ovr", 32'(overrun), 0);

        // 6: reset mid-frame, then a full 81 frame
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        chk("t6_rst_dout", 32'(dout), 0);
        chk("t6_rst_valid", 32'(dout_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        send_frame(8'h81, 1, 0);
        chk("t6_dout", 32'(dout), 32'h81);
        chk("t6_valid", 32'(dout_valid), 1);

        // Start on the last-bit cycle: the word completes and the FSM stays busy.
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < W - 1; i++) cyc(1, 0, 1, 0, 1);
        cyc(1, 1, 1, 1, 1);
        chk("lastbit_start_dout", 32'(dout), 32'h01);
        chk("lastbit_start_busy", 32'(busy), 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                1'($urandom),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 11) == 0),
                1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
